// File: rtl/conv3x3_mac_if.sv
// Window/result bus between the 3x3 collector and the conv3x3_mac stage.
// master: window producer (drives pixels and stall, observes results).
// slave : conv3x3_mac (consumes the window, drives the result pixel).
interface conv3x3_mac_if;
  logic [7:0] win1, win2, win3;
  logic [7:0] win4, win5, win6;
  logic [7:0] win7, win8, win9;
  logic       stall;
  logic [7:0] pix_out;
  logic       out_valid;
  logic       out_eol;

  modport master (
    output win1, win2, win3, win4, win5, win6, win7, win8, win9, stall,
    input  pix_out, out_valid, out_eol
  );

  modport slave (
    input  win1, win2, win3, win4, win5, win6, win7, win8, win9, stall,
    output pix_out, out_valid, out_eol
  );
endinterface

// File: rtl/conv3x3_mac.sv
// conv3x3_mac: 3x3 signed-kernel MAC over an unsigned pixel window, plus bias,
// arithmetic-shift requantisation and 8-bit saturation. Four register stages,
// one window per cycle, end-of-row marker on the last output of each row.
// Build option: CONV_RELU_EN selects unsigned [0,255] clamping (ReLU folded in);
// without it the result is signed, clamped to [-128,127].
module conv3x3_mac #(
  parameter int IMAGE_WIDTH = 128,
  parameter int ACC_W       = 21
) (
  input  logic                clk,
  input  logic                rst_n,
  conv3x3_mac_if.slave        bus,
  input  logic [7:0]          stage_width,
  input  logic                w_load,
  input  logic [7:0]          w_data,
  input  logic [15:0]         bias,
  input  logic [3:0]          shift,
  output logic                w_ready
);

  localparam int COL_W = (IMAGE_WIDTH > 2) ? $clog2(IMAGE_WIDTH) : 1;

  logic signed [7:0]       tap [9];
  logic [3:0]              idx;
  logic                    accept;
  logic [7:0]              win [9];
  logic signed [16:0]      prod [9];
  logic signed [16:0]      p1 [9];
  logic signed [18:0]      row_sum [3];
  logic signed [18:0]      s2 [3];
  logic signed [ACC_W-1:0] acc3;
  logic signed [ACC_W-1:0] q;
  logic [7:0]              sat;
  logic                    v1, v2, v3;
  logic [COL_W-1:0]        col;
  logic                    row_last;

  assign accept = !bus.stall && w_ready && !w_load;

  // Kernel tap loader: sequential writes, ready once all nine taps are in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 9; i++) tap[i] <= '0;
      idx     <= '0;
      w_ready <= 1'b0;
    end else if (w_load) begin
      tap[idx] <= w_data;
      if (idx == 4'd8) begin
        idx     <= '0;
        w_ready <= 1'b1;
      end else begin
        idx <= idx + 4'd1;
        if (idx == 4'd0) w_ready <= 1'b0;
      end
    end
  end

  // Window unpack and per-tap products (unsigned pixel times signed tap).
  always_comb begin
    win[0] = bus.win1; win[1] = bus.win2; win[2] = bus.win3;
    win[3] = bus.win4; win[4] = bus.win5; win[5] = bus.win6;
    win[6] = bus.win7; win[7] = bus.win8; win[8] = bus.win9;
    for (int unsigned i = 0; i < 9; i++)
      prod[i] = $signed({9'd0, win[i]}) * $signed({{9{tap[i][7]}}, tap[i]});
  end

  // Row partial sums of the registered products.
  always_comb begin
    for (int unsigned r = 0; r < 3; r++)
      row_sum[r] = {{2{p1[3*r][16]}}, p1[3*r]}
                 + {{2{p1[3*r+1][16]}}, p1[3*r+1]}
                 + {{2{p1[3*r+2][16]}}, p1[3*r+2]};
  end

  // Datapath registers for stages 1-3; qualified downstream by the valid bits.
  always_ff @(posedge clk) begin
    p1   <= prod;
    s2   <= row_sum;
    acc3 <= {{(ACC_W-19){s2[0][18]}}, s2[0]}
          + {{(ACC_W-19){s2[1][18]}}, s2[1]}
          + {{(ACC_W-19){s2[2][18]}}, s2[2]}
          + {{(ACC_W-16){bias[15]}}, bias};
  end

  // Requantise and clamp to the 8-bit output range.
  always_comb begin
    q   = acc3 >>> shift;
    sat = '0;
`ifdef CONV_RELU_EN
    begin : relu_sat
      localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(255);
      if (q[ACC_W-1])      sat = '0;
      else if (q > SAT_HI) sat = '1;
      else                 sat = q[7:0];
    end
`else
    begin : signed_sat
      localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(127);
      localparam logic signed [ACC_W-1:0] SAT_LO = -ACC_W'(128);
      if (q < SAT_LO)      sat = 8'h80;
      else if (q > SAT_HI) sat = 8'h7F;
      else                 sat = q[7:0];
    end
`endif
  end

  assign row_last = (8'(col) == stage_width - 8'd3);

  // Valid pipeline, output register and column counter for the row marker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1            <= 1'b0;
      v2            <= 1'b0;
      v3            <= 1'b0;
      bus.pix_out   <= '0;
      bus.out_valid <= 1'b0;
      bus.out_eol   <= 1'b0;
      col           <= '0;
    end else begin
      v1            <= accept;
      v2            <= v1;
      v3            <= v2;
      bus.out_valid <= v3;
      bus.out_eol   <= v3 && row_last;
      if (v3) begin
        bus.pix_out <= sat;
        col         <= row_last ? '0 : col + COL_W'(1);
      end
    end
  end

endmodule
